// File: rtl/loader_dma_ctrl.sv
// Burst load sequencer: turns (target, base, len) commands plus a valid/ready beat
// stream into single-beat writes on the accelerator loader port.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready_o high, illegal commands flagged
// RUN   | accepting beats, one registered write per handshake
// DONE  | last write on the port; done/weight_loaded pulse, then IDLE
module loader_dma_ctrl #(
  parameter int K_CHANNELS  = 6,
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 12,
  parameter int LEN_W       = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_async_n_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [1:0]                     cmd_target_i,
  input  logic [SRAM_ADDR_W-1:0]         cmd_base_addr_i,
  input  logic [LEN_W-1:0]               cmd_len_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [K_CHANNELS*DATA_W-1:0]   s_data_i,
  input  logic                           core_busy_i,
  input  logic                           abort_i,
  output logic [1:0]                     loader_target_sel_o,
  output logic                           loader_wr_en_o,
  output logic [31:0]                    loader_wr_addr_o,
  output logic [K_CHANNELS*DATA_W-1:0]   loader_wr_data_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           weight_loaded_o,
  output logic                           err_o
);

  localparam int PAYLOAD_W = K_CHANNELS * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             target_q, target_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;

  logic                   wr_en_q, wr_en_d;
  logic [SRAM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PAYLOAD_W-1:0]   wr_data_q, wr_data_d;
  logic [1:0]             tsel_q, tsel_d;
  logic                   done_q, done_d;
  logic                   wl_q, wl_d;
  logic                   err_q, err_d;

  logic cmd_hs;
  logic cmd_illegal;
  logic beat_hs;
  logic last_beat;

  // Global-buffer bursts stall while the systolic core owns the buffer.
  assign s_ready_o   = (state_q == ST_RUN) && !abort_i &&
                       !((target_q == 2'd0) && core_busy_i);
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);

  assign cmd_hs      = cmd_valid_i && (state_q == ST_IDLE);
  assign cmd_illegal = (cmd_target_i == 2'd3) || (cmd_len_i == '0);
  assign beat_hs     = s_valid_i && s_ready_o;
  assign last_beat   = (idx_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    wl_d      = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          if (cmd_illegal) begin
            err_d = 1'b1;
          end else begin
            target_d = cmd_target_i;
            base_d   = cmd_base_addr_i;
            len_d    = cmd_len_i;
            idx_d    = '0;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (beat_hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + SRAM_ADDR_W'(idx_q);
          wr_data_d = s_data_i;
          idx_d     = idx_q + LEN_W'(1);
          if (last_beat) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            wl_d    = (target_q != 2'd0);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Target select stays valid one cycle past the burst so a trailing write
    // (last beat or pre-abort beat) still carries its target.
    if (state_d != ST_IDLE) begin
      tsel_d = target_d;
    end else if (state_q != ST_IDLE) begin
      tsel_d = target_q;
    end else begin
      tsel_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q   <= ST_IDLE;
      target_q  <= 2'd0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tsel_q    <= 2'd0;
      done_q    <= 1'b0;
      wl_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tsel_q    <= tsel_d;
      done_q    <= done_d;
      wl_q      <= wl_d;
      err_q     <= err_d;
    end
  end

  assign loader_wr_en_o      = wr_en_q;
  assign loader_wr_addr_o    = 32'(wr_addr_q);
  assign loader_wr_data_o    = wr_data_q;
  assign loader_target_sel_o = tsel_q;
  assign done_o              = done_q;
  assign weight_loaded_o     = wl_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_loader_dma_ctrl.sv
// Scoreboard bench for loader_dma_ctrl: stimulus pushes expected writes/pulses,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_loader_dma_ctrl;
  localparam int K  = 6;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int PW = K * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_target;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_data;
  logic          core_busy;
  logic          abort;
  logic [1:0]    tsel;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [PW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          wl;
  logic          err;

  loader_dma_ctrl #(.K_CHANNELS(K), .DATA_W(DW), .SRAM_ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_async_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_target_i(cmd_target),
    .cmd_base_addr_i(cmd_base), .cmd_len_i(cmd_len),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .core_busy_i(core_busy), .abort_i(abort),
    .loader_target_sel_o(tsel), .loader_wr_en_o(wr_en), .loader_wr_addr_o(wr_addr),
    .loader_wr_data_o(wr_data), .busy_o(busy), .done_o(done),
    .weight_loaded_o(wl), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cyc; logic [1:0] tgt; logic [31:0] addr; logic [PW-1:0] data; } wr_t;
  typedef struct { int cyc; logic wl; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  int  err_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, compare DUT strobes against what the model scheduled.
  wr_t mw;
  dn_t md;
  int  me;
  bit  exp_wr, exp_dn, exp_er;
  always @(negedge clk) begin
    if (rst_n) begin
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        mw = wr_q.pop_front();
        chk("write_missing_cycle", cyc, mw.cyc);
      end
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      chk("wr_en", wr_en, exp_wr);
      if (wr_en && exp_wr) begin
        mw = wr_q.pop_front();
        chk("wr_addr", wr_addr, mw.addr);
        chk("wr_data", wr_data, mw.data);
        chk("target_sel", tsel, mw.tgt);
      end

      while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
        md = dn_q.pop_front();
        chk("done_missing_cycle", cyc, md.cyc);
      end
      exp_dn = (dn_q.size() > 0) && (dn_q[0].cyc == cyc);
      chk("done", done, exp_dn);
      chk("weight_loaded", wl, exp_dn ? dn_q[0].wl : 1'b0);
      if (exp_dn) md = dn_q.pop_front();

      while (err_q.size() > 0 && err_q[0] < cyc) begin
        me = err_q.pop_front();
        chk("err_missing_cycle", cyc, me);
      end
      exp_er = (err_q.size() > 0) && (err_q[0] == cyc);
      chk("err", err, exp_er);
      if (exp_er) me = err_q.pop_front();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_wr_addr"}, wr_addr, 32'h0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_target_sel"}, tsel, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_weight_loaded"}, wl, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic issue_cmd(input logic [1:0] tgt, input logic [AW-1:0] base, input logic [LW-1:0] len);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_base   = base;
    cmd_len    = len;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    if (tgt == 2'd3 || len == 0) err_q.push_back(cyc + 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic illegal(input logic [1:0] tgt, input logic [AW-1:0] base, input logic [LW-1:0] len);
    issue_cmd(tgt, base, len);
    @(negedge clk);
    chk("busy_after_illegal", busy, 1'b0);
    chk("cmd_ready_after_illegal", cmd_ready, 1'b1);
    tick();
  endtask

  task automatic random_payload(output logic [PW-1:0] d);
    for (int k = 0; k < K; k++) d[k*DW +: DW] = $urandom();
  endtask

  // One burst; stall_after/stall_len force core_busy after that many beats,
  // abort_beat (>=0) raises abort together with that beat's valid.
  task automatic burst(input logic [1:0] tgt, input logic [AW-1:0] base, input int len,
                       input int pvalid, input int pbusy, input int stall_after,
                       input int stall_len, input int abort_beat);
    int beat = 0;
    int guard = 0;
    int stall_rem = 0;
    bit hs, ab, exp_rdy, ended, aborted;
    logic [PW-1:0] d;
    wr_t w;
    dn_t dn;
    ended = 1'b0;
    aborted = 1'b0;
    issue_cmd(tgt, base, LW'(len));
    while (!ended) begin
      ab        = (beat == abort_beat);
      s_valid   = ab || ($urandom_range(99) < pvalid);
      abort     = ab;
      core_busy = (stall_rem > 0) || ($urandom_range(99) < pbusy);
      random_payload(d);
      s_data = d;
      @(negedge clk);
      exp_rdy = !ab && !(tgt == 2'd0 && core_busy);
      chk("s_ready", s_ready, exp_rdy);
      chk("busy_run", busy, 1'b1);
      chk("cmd_ready_run", cmd_ready, 1'b0);
      hs = s_valid && exp_rdy;
      if (stall_rem > 0) stall_rem--;
      if (hs) begin
        w.cyc  = cyc + 1;
        w.tgt  = tgt;
        w.addr = 32'((int'(base) + beat) % (1 << AW));
        w.data = d;
        wr_q.push_back(w);
        beat++;
        if (beat == stall_after && stall_len > 0) stall_rem = stall_len;
        if (beat == len) begin
          dn.cyc = cyc + 1;
          dn.wl  = (tgt != 2'd0);
          dn_q.push_back(dn);
          ended = 1'b1;
        end
      end
      if (ab) begin
        ended = 1'b1;
        aborted = 1'b1;
      end
      guard++;
      if (guard > 500) begin
        chk("burst_timeout_beats", beat, len);
        ended = 1'b1;
      end
      tick();
    end
    s_valid   = 1'b0;
    abort     = 1'b0;
    core_busy = 1'b0;
    @(negedge clk);
    if (aborted) begin
      chk("busy_after_abort", busy, 1'b0);
      chk("cmd_ready_after_abort", cmd_ready, 1'b1);
    end else begin
      chk("busy_done", busy, 1'b1);
      chk("cmd_ready_done", cmd_ready, 1'b0);
    end
    tick();
  endtask

  task automatic reset_mid_burst();
    logic [PW-1:0] d;
    wr_t w;
    issue_cmd(2'd0, 12'h100, 16'd8);
    for (int b = 0; b < 3; b++) begin
      s_valid = 1'b1;
      random_payload(d);
      s_data = d;
      @(negedge clk);
      chk("s_ready_prereset", s_ready, 1'b1);
      w.cyc  = cyc + 1;
      w.tgt  = 2'd0;
      w.addr = 32'h100 + 32'(b);
      w.data = d;
      wr_q.push_back(w);
      tick();
    end
    random_payload(d);
    s_data = d;
    rst_n = 1'b0;
    wr_q.delete();
    dn_q.delete();
    #1;
    check_reset_vals("reset_mid");
    tick();
    s_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int tgt, len, ab, base;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 2'd0;
    cmd_base   = '0;
    cmd_len    = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    core_busy  = 1'b0;
    abort      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    burst(2'd0, 12'h010, 4, 100, 0, -1, 0, -1);
    burst(2'd0, 12'h020, 8, 100, 0, 3, 5, -1);
    burst(2'd1, 12'h040, 8, 100, 0, 3, 5, -1);
    burst(2'd1, 12'hFFE, 4, 100, 0, -1, 0, -1);
    illegal(2'd3, 12'h010, 16'd5);
    illegal(2'd0, 12'h010, 16'd0);
    burst(2'd2, 12'h000, 6, 100, 0, -1, 0, 2);
    burst(2'd2, 12'h008, 3, 100, 0, -1, 0, -1);
    burst(2'd0, 12'h030, 1, 100, 0, -1, 0, -1);
    reset_mid_burst();
    burst(2'd0, 12'h200, 4, 100, 0, -1, 0, -1);

    repeat (40) begin
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(1) == 0) illegal(2'd3, 12'($urandom()), 16'($urandom_range(1, 9)));
        else                        illegal(2'($urandom_range(2)), 12'($urandom()), 16'd0);
      end else begin
        tgt  = $urandom_range(2);
        len  = $urandom_range(1, 10);
        base = $urandom_range(4095);
        ab   = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
        burst(2'(tgt), 12'(base), len, 70, 25, -1, 0, ab);
      end
    end

    repeat (5) tick();
    chk("writes_outstanding", wr_q.size(), 0);
    chk("done_outstanding", dn_q.size(), 0);
    chk("err_outstanding", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
